// File: rtl/regfile_arbiter_if.sv
// Single-word read/write request channel between one requester and regfile_arbiter.
// The requester drives the master side; the arbiter drives ack/rdata on the slave side.
interface regfile_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin two-requester sequencer for a 4x4 register file with active-low enables.
// Define REGFILE_ARB_FIXED_PRIO_EN to make requester A win every tie instead.
module regfile_arbiter #(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 2,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  regfile_arbiter_if.slave  a,
  regfile_arbiter_if.slave  b,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [ADDR_W-1:0] rf_write_add,
  output logic              rf_write_en_n,
  output logic [ADDR_W-1:0] rf_read_add,
  output logic              rf_read_en_n,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic              busy,
  output logic              grant_b
);

  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_REL, R_EN, ACK} state_t;

  state_t            state, next_state;
  logic [2:0]        wait_cnt;
  logic              any_req, pick_b, sel_we, read_done;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              a_ack_q, b_ack_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  logic [DATA_W-1:0] data_in_d, a_rdata_d, b_rdata_d;
  logic [ADDR_W-1:0] write_add_d, read_add_d;
  logic              write_en_n_d, read_en_n_d, busy_d, grant_b_d, a_ack_d, b_ack_d;

  assign a.ack   = a_ack_q;
  assign a.rdata = a_rdata_q;
  assign b.ack   = b_ack_q;
  assign b.rdata = b_rdata_q;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  assign pick_b = b.req & ~a.req;
`else
  logic last_grant_b;

  // B owned the previous transaction means A wins the next tie, and vice versa.
  assign pick_b = b.req & (~a.req | ~last_grant_b);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                last_grant_b <= 1'b1;
    else if (next_state == ACK)  last_grant_b <= grant_b;
  end
`endif

  assign any_req   = a.req | b.req;
  assign sel_we    = pick_b ? b.we    : a.we;
  assign sel_addr  = pick_b ? b.addr  : a.addr;
  assign sel_wdata = pick_b ? b.wdata : a.wdata;
  assign read_done = (state == R_EN) && (wait_cnt == 3'(READ_WAIT));

  // State and every output are registered together so outputs track the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      rf_data_in    <= '0;
      rf_write_add  <= '0;
      rf_write_en_n <= 1'b1;
      rf_read_add   <= '0;
      rf_read_en_n  <= 1'b1;
      busy          <= 1'b0;
      grant_b       <= 1'b0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
    end else begin
      state         <= next_state;
      wait_cnt      <= (state == R_EN && !read_done) ? wait_cnt + 3'd1 : '0;
      rf_data_in    <= data_in_d;
      rf_write_add  <= write_add_d;
      rf_write_en_n <= write_en_n_d;
      rf_read_add   <= read_add_d;
      rf_read_en_n  <= read_en_n_d;
      busy          <= busy_d;
      grant_b       <= grant_b_d;
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = sel_we ? W_SETUP : R_EN;
      W_SETUP: next_state = W_PULSE;
      W_PULSE: next_state = W_REL;
      W_REL:   next_state = ACK;
      R_EN:    if (read_done) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered value matches the state being entered.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    data_in_d   = rf_data_in;
    write_add_d = rf_write_add;
    read_add_d  = rf_read_add;
    grant_b_d   = grant_b;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;

    if (state == IDLE && any_req) begin
      grant_b_d = pick_b;
      if (sel_we) begin
        write_add_d = sel_addr;
        data_in_d   = sel_wdata;
      end else begin
        read_add_d  = sel_addr;
      end
    end

    if (read_done) begin
      if (grant_b) b_rdata_d = rf_data_out;
      else         a_rdata_d = rf_data_out;
    end

    write_en_n_d = (next_state != W_PULSE);
    read_en_n_d  = (next_state != R_EN);
    busy_d       = (next_state != IDLE);
    a_ack_d      = (next_state == ACK) && !grant_b_d;
    b_ack_d      = (next_state == ACK) &&  grant_b_d;
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a behavioural register file model sits on the rf_* ports,
// and a second instance with READ_WAIT=3 covers the long read window.
module tb_regfile_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  regfile_arbiter_if #(.DATA_W(4), .ADDR_W(2)) a_if ();
  regfile_arbiter_if #(.DATA_W(4), .ADDR_W(2)) b_if ();
  regfile_arbiter_if #(.DATA_W(4), .ADDR_W(2)) c_if ();
  regfile_arbiter_if #(.DATA_W(4), .ADDR_W(2)) d_if ();

  logic [3:0] rf_data_in, rf_data_out, rf_data_in3, rf_data_out3;
  logic [1:0] rf_write_add, rf_read_add, rf_write_add3, rf_read_add3;
  logic       rf_write_en_n, rf_read_en_n, rf_write_en_n3, rf_read_en_n3;
  logic       busy, grant_b, busy3, grant_b3;

  regfile_arbiter #(.DATA_W(4), .ADDR_W(2), .READ_WAIT(1)) dut (
    .clk(clk), .reset_n(reset_n), .a(a_if.slave), .b(b_if.slave),
    .rf_data_in(rf_data_in), .rf_write_add(rf_write_add), .rf_write_en_n(rf_write_en_n),
    .rf_read_add(rf_read_add), .rf_read_en_n(rf_read_en_n), .rf_data_out(rf_data_out),
    .busy(busy), .grant_b(grant_b)
  );

  regfile_arbiter #(.DATA_W(4), .ADDR_W(2), .READ_WAIT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .a(c_if.slave), .b(d_if.slave),
    .rf_data_in(rf_data_in3), .rf_write_add(rf_write_add3), .rf_write_en_n(rf_write_en_n3),
    .rf_read_add(rf_read_add3), .rf_read_en_n(rf_read_en_n3), .rf_data_out(rf_data_out3),
    .busy(busy3), .grant_b(grant_b3)
  );

  // Register file models: write commits on the low-to-high return of write_en_n.
  logic [3:0] mem  [4];
  logic [3:0] mem3 [4];

  always @(posedge rf_write_en_n)  mem[rf_write_add]   = rf_data_in;
  always @(posedge rf_write_en_n3) mem3[rf_write_add3] = rf_data_in3;
  assign rf_data_out  = rf_read_en_n  ? 4'h0 : mem[rf_read_add];
  assign rf_data_out3 = rf_read_en_n3 ? 4'h0 : mem3[rf_read_add3];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic who_b, input logic req, input logic we,
                       input logic [1:0] addr, input logic [3:0] wdata);
    if (who_b) begin
      b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata;
    end else begin
      a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  // One transaction started in an IDLE cycle; returns to IDLE after the ack cycle.
  task automatic txn(input logic who_b, input logic we, input logic [1:0] addr,
                     input logic [3:0] wdata, input int exp_lat, input int exp_low,
                     input string tag);
    int n;
    int low;
    logic ack_seen;
    n = 0;
    low = 0;
    ack_seen = 1'b0;
    drive(who_b, 1'b1, we, addr, wdata);
    while (!ack_seen && n < 20) begin
      tick();
      n++;
      if (!rf_read_en_n) low++;
      ack_seen = who_b ? b_if.ack : a_if.ack;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_ren_low"}, low, exp_low);
    drive(who_b, 1'b0, 1'b0, 2'd0, 4'd0);
    tick();
  endtask

  logic [3:0] exp_rd [4];
  int         order  [4];
  int         exp_order [4];

  initial begin
    int k;
    int n;
    int low;
    int acks;

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    c_if.req = 1'b0; c_if.we = 1'b0; c_if.addr = 2'd0; c_if.wdata = 4'd0;
    d_if.req = 1'b0; d_if.we = 1'b0; d_if.addr = 2'd0; d_if.wdata = 4'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      mem[i]  = 4'h0;
      mem3[i] = 4'h0;
    end
    mem3[2] = 4'hA;
    tick();

    // Reset values
    check("rst_busy", busy, 0);
    check("rst_grant_b", grant_b, 0);
    check("rst_wen_n", rf_write_en_n, 1);
    check("rst_ren_n", rf_read_en_n, 1);
    check("rst_wadd", rf_write_add, 0);
    check("rst_din", rf_data_in, 0);
    check("rst_radd", rf_read_add, 0);
    check("rst_acks", {a_if.ack, b_if.ack}, 0);
    check("rst_rdata", {a_if.rdata, b_if.rdata}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // A writes 0001 to address 0, cycle by cycle
    drive(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001);
    tick();
    check("w1_c1_wen_n", rf_write_en_n, 1);
    check("w1_c1_din", rf_data_in, 1);
    check("w1_c1_busy", busy, 1);
    tick();
    check("w1_c2_wen_n", rf_write_en_n, 0);
    check("w1_c2_wadd", rf_write_add, 0);
    check("w1_c2_ack", a_if.ack, 0);
    tick();
    check("w1_c3_wen_n", rf_write_en_n, 1);
    check("w1_c3_din", rf_data_in, 1);
    check("w1_c3_ack", a_if.ack, 0);
    tick();
    check("w1_c4_ack", a_if.ack, 1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    tick();
    check("w1_c5_ack", a_if.ack, 0);
    check("w1_c5_busy", busy, 0);
    check("w1_mem0", mem[0], 1);

    // A fills addresses 1..3, B reads all four back
    txn(1'b0, 1'b1, 2'd1, 4'b0010, 4, 0, "w_a1");
    txn(1'b0, 1'b1, 2'd2, 4'b0100, 4, 0, "w_a2");
    txn(1'b0, 1'b1, 2'd3, 4'b1000, 4, 0, "w_a3");
    exp_rd[0] = 4'b0001; exp_rd[1] = 4'b0010; exp_rd[2] = 4'b0100; exp_rd[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 1'b0, 2'(i), 4'd0, 3, 2, $sformatf("r_b%0d", i));
      check($sformatf("r_b%0d_data", i), b_if.rdata, exp_rd[i]);
    end
    check("r_b_a_rdata_untouched", a_if.rdata, 0);

    // Both requesting continuously from reset
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd1, 4'd0);
    k = 0;
    n = 0;
    acks = 0;
    while (k < 4 && n < 40) begin
      tick();
      n++;
      if (a_if.ack) begin order[k] = 0; k++; end
      if (b_if.ack) begin order[k] = 1; k++; acks++; end
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    tick();
    tick();
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
    check("rr_b_acks", acks, 0);
`else
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    check("rr_b_acks", acks, 2);
`endif
    check("rr_count", k, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), order[i], exp_order[i]);

    // B arrives during an A write pulse; A's read data must survive B's read
    txn(1'b0, 1'b0, 2'd3, 4'd0, 3, 2, "pre_a_rd");
    check("pre_a_rdata", a_if.rdata, 8);
    drive(1'b0, 1'b1, 1'b1, 2'd0, 4'b0101);
    tick();
    tick();
    check("ov_c2_wen_n", rf_write_en_n, 0);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 4'd0);
    tick();
    tick();
    check("ov_c4_a_ack", a_if.ack, 1);
    check("ov_c4_grant_b", grant_b, 0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    tick();
    check("ov_c5_busy", busy, 0);
    tick();
    check("ov_c6_grant_b", grant_b, 1);
    check("ov_c6_busy", busy, 1);
    tick();
    check("ov_c7_b_ack", b_if.ack, 0);
    tick();
    check("ov_c8_b_ack", b_if.ack, 1);
    check("ov_b_rdata", b_if.rdata, 4);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    tick();
    check("ov_a_rdata_kept", a_if.rdata, 8);
    check("ov_mem0", mem[0], 5);

    // Reset asserted in the middle of a read
    drive(1'b0, 1'b1, 1'b0, 2'd1, 4'd0);
    tick();
    check("rr_mid_ren_n", rf_read_en_n, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rr_mid_rst_ren_n", rf_read_en_n, 1);
    check("rr_mid_rst_busy", busy, 0);
    check("rr_mid_rst_a_rdata", a_if.rdata, 0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_if.ack) acks++;
    end
    check("rr_mid_no_ack", acks, 0);
    txn(1'b0, 1'b0, 2'd1, 4'd0, 3, 2, "rr_reissue");
    check("rr_reissue_data", a_if.rdata, 2);

    // READ_WAIT=3 instance: four-cycle read window, ack in cycle 5
    c_if.req = 1'b1; c_if.we = 1'b0; c_if.addr = 2'd2;
    n = 0;
    low = 0;
    while (!c_if.ack && n < 20) begin
      tick();
      n++;
      if (!rf_read_en_n3) low++;
    end
    check("rw3_lat", n, 5);
    check("rw3_ren_low", low, 4);
    check("rw3_data", c_if.rdata, 10);
    c_if.req = 1'b0;
    tick();
    check("rw3_busy", busy3, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
Two-requester arbiter and sequencer for the 4-entry x 4-bit register file, which has active-low read/write enables.
- Accepts single-word read/write transactions from requesters A and B over a req/ack handshake.
- Arbitrates round-robin between them.
- Generates the register file's setup/strobe/release write pulse and its read-enable window.
- Sits between the register file and its consumers; it is the only block that drives the register file's ports.

Parameters:
DATA_W, 4, register file word width
ADDR_W, 2, register file address width
READ_WAIT, 1, extra cycles read_en_n is held low before rf_data_out is captured (0..7)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
a_req  input  1  requester A transaction request
a_we  input  1  A: 1=write, 0=read
a_addr  input  ADDR_W  A register address
a_wdata  input  DATA_W  A write data
a_ack  output  1  A completion pulse, one cycle
a_rdata  output  DATA_W  A read data, valid when a_ack is high
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as A, for requester B
rf_data_in  output  DATA_W  to register file data_in
rf_write_add  output  ADDR_W  to register file write_add
rf_write_en_n  output  1  to register file write_en (active low; the write commits on the low-to-high return)
rf_read_add  output  ADDR_W  to register file read_add
rf_read_en_n  output  1  to register file read_en (active low)
rf_data_out  input  DATA_W  from register file data_out
busy  output  1  high whenever the FSM is not in IDLE
grant_b  output  1  0=A, 1=B owns the current transaction; meaningful only while busy

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low. All outputs are registered.
- Reset values:
  - rf_write_en_n=1, rf_read_en_n=1.
  - rf_data_in, rf_write_add, rf_read_add = 0.
  - a_ack=b_ack=0, a_rdata=b_rdata=0.
  - busy=0, grant_b=0, FSM=IDLE.
  - last_grant=B, so A wins the first tie.
- FSM states: IDLE, W_SETUP, W_PULSE, W_REL, R_EN, ACK.
- IDLE:
  - If a_req or b_req is high, grant one requester.
  - Latch that requester's we/addr/wdata into internal registers.
  - Go to W_SETUP if we=1, else R_EN. Requester fields are not sampled again after the grant.
- Arbitration:
  - Only one requester asserting: it wins.
  - Both asserting: the one not equal to last_grant wins.
  - last_grant updates on entry to ACK.
- W_SETUP (1 cycle): drive rf_write_add/rf_data_in from the latched fields; rf_write_en_n=1.
- W_PULSE (1 cycle): rf_write_en_n=0; address and data held.
- W_REL (1 cycle): rf_write_en_n=1; address and data held. Go to ACK.
- R_EN:
  - rf_read_add = latched addr; rf_read_en_n=0 for READ_WAIT+1 cycles, using an internal counter.
  - On the last of those cycles, capture rf_data_out into the granted requester's rdata.
  - Then set rf_read_en_n=1 and go to ACK.
- ACK (1 cycle): granted requester's ack=1, other ack=0; then go to IDLE.
- rdata of the non-granted requester is never modified. rdata holds its value until that requester's next read.
- Latency, counted from the IDLE cycle in which req is sampled (cycle 0):
  - Write: ack in cycle 4.
  - Read: ack in cycle READ_WAIT+2, i.e. cycle 3 at the default.
  - Back-to-back throughput: one transaction per 5 cycles for writes, per READ_WAIT+3 cycles for reads.
- Handshake rules:
  - A requester must hold req until ack.
  - A requester must drop req at the clock edge ending its ack cycle. If req is still high in the following IDLE, it is treated as a new request.
  - req dropped after the grant: the transaction still completes and ack still pulses.
  - req dropped before the grant: ignored, no side effects.
- Simultaneous events: a request arriving while busy waits; there is no queueing beyond the req level itself. With both requesting continuously, grants alternate A,B,A,B.
- Reset mid-operation:
  - All outputs return to reset values immediately, with no ack.
  - A write interrupted in W_PULSE may or may not commit in the register file; requesters must reissue it.
  - Reset in any other state has no register file side effect.
- Address wrap: addresses are ADDR_W bits with no range check; all 2^ADDR_W entries are valid.

Optional Feature:
Macro REGFILE_ARB_FIXED_PRIO_EN.
- Defined: requester A always wins ties; last_grant is not implemented. B can be starved while A requests continuously.
- Not defined: round-robin as above.
- The FSM, latency and handshake are identical in both builds.

Test Plan:
- After reset, A writes 0001 to address 0 -> rf_write_en_n goes 1,0,1 across cycles 1-3 with rf_write_add=00 and rf_data_in=0001 held; a_ack=1 in cycle 4 only.
- A writes 0010/0100/1000 to addresses 1/2/3, then B reads addresses 0-3 -> b_rdata = 0001, 0010, 0100, 1000; each b_ack arrives 3 cycles after its grant; rf_read_en_n low exactly 2 cycles per read.
- A and B both request continuously from reset -> grant order A,B,A,B. With REGFILE_ARB_FIXED_PRIO_EN defined -> A,A,A with B never acked.
- B raises req while an A write is in W_PULSE -> B is granted in the IDLE cycle after a_ack; a_rdata is unchanged by B's read.
- reset_n pulsed low during R_EN -> rf_read_en_n=1 and busy=0 immediately; no ack issued; a re-issued read completes normally.
- READ_WAIT=3 build, single read -> rf_read_en_n low for 4 cycles; ack in cycle 5.
